wtm_product_accumulator: RTL and testbench

//   Downstream consumer of the registered 32x32 Wallace-tree multiplier. Issues operand pairs
//   to the multiplier under a valid/ready handshake, tracks each in-flight product through the

---
 rtl/wtm_pkg.sv | 14 +
 rtl/wtm_product_accumulator_valid_delay_line.sv | 25 ++
 rtl/wtm_product_accumulator.sv | 130 +++++++++++++
 tb/tb_wtm_product_accumulator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wtm_pkg.sv
// Shared constants and FSM encoding for the Wallace-tree multiplier product accumulator.
package wtm_pkg;

  localparam int PROD_W   = 64;
  localparam int MULT_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wtm_product_accumulator_valid_delay_line.sv
// Valid tag shift register that tracks products through the multiplier's fixed latency.
module valid_delay_line
  import wtm_pkg::*;
#(
  parameter int DEPTH = MULT_LAT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_din,
  output logic o_dout
);

  logic [DEPTH-1:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_shift <= '0;
    end else begin
      r_shift <= {r_shift[DEPTH-2:0], i_din};
    end
  end

  assign o_dout = r_shift[DEPTH-1];

endmodule

// File: rtl/wtm_product_accumulator.sv
// Issues operand pairs to the external registered multiplier and sums a programmed
// number of its products, presenting the total under a valid/ready handshake.
module wtm_product_accumulator
  import wtm_pkg::*;
#(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  input  logic [31:0]       i_op_a,
  input  logic [31:0]       i_op_b,
  output logic [31:0]       o_mult_a,
  output logic [31:0]       o_mult_b,
  input  logic [PROD_W-1:0] i_prod_in,
  output logic [ACC_W-1:0]  o_acc_out,
  output logic              o_acc_valid,
  input  logic              i_acc_ready,
  output logic              o_overflow,
  output logic              o_busy
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_recv_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_acc_valid;
  logic               r_overflow;
  logic               r_busy;
  logic               r_op_ready;

  logic               w_accept;
  logic               w_prod_valid;
  logic               w_summing;
  logic [ACC_W:0]     w_sum;

  assign o_mult_a = i_op_a;
  assign o_mult_b = i_op_b;

  // op_ready is only ever high in ACCUM, so acceptance alone marks an issued pair.
  assign w_accept  = i_op_valid & r_op_ready;
  assign w_summing = (r_state == ACCUM || r_state == DRAIN) && w_prod_valid;
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W - PROD_W + 1){1'b0}}, i_prod_in};

  valid_delay_line #(
    .DEPTH (MULT_LAT)
  ) u_valid_delay_line (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_din   (w_accept),
    .o_dout  (w_prod_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_op_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_len       <= i_len;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_acc       <= '0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b1;
            if (i_len == '0) begin
              r_state     <= DONE;
              r_acc_valid <= 1'b1;
            end else begin
              r_state    <= ACCUM;
              r_op_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (r_issue_cnt + CNT_W'(1) == r_len) begin
              r_state    <= DRAIN;
              r_op_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
        end
        DONE: begin
          if (i_acc_ready) begin
            r_state     <= IDLE;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      // The last product can only arrive in DRAIN, so this never fights the ACCUM exit.
      if (w_summing) begin
        r_acc      <= w_sum[ACC_W-1:0];
        r_overflow <= r_overflow | w_sum[ACC_W];
        r_recv_cnt <= r_recv_cnt + CNT_W'(1);
        if (r_recv_cnt + CNT_W'(1) == r_len) begin
          r_state     <= DONE;
          r_acc_valid <= 1'b1;
          r_op_ready  <= 1'b0;
        end
      end
    end
  end

  assign o_op_ready  = r_op_ready;
  assign o_acc_out   = r_acc;
  assign o_acc_valid = r_acc_valid;
  assign o_overflow  = r_overflow;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_wtm_product_accumulator.sv
// Directed bench for wtm_product_accumulator: a 72-bit and a 64-bit accumulator share
// the same stimulus and a behavioural 2-stage registered multiplier.
module tb_wtm_product_accumulator;

  logic        clk;
  logic        resetN;
  logic        start;
  logic [7:0]  len;
  logic        opValid;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        accReady;
  logic [63:0] prodIn;
  logic [63:0] mulStage1;

  logic        opReady72, accValid72, overflow72, busy72;
  logic [71:0] accOut72;
  logic [31:0] multA72, multB72;
  logic        opReady64, accValid64, overflow64, busy64;
  logic [63:0] accOut64;
  logic [31:0] multA64, multB64;

  int nVectors = 0;
  int nMiscompares = 0;

  wtm_product_accumulator dut (
    .i_clk(clk), .i_reset(resetN), .i_start(start), .i_len(len),
    .i_op_valid(opValid), .o_op_ready(opReady72), .i_op_a(opA), .i_op_b(opB),
    .o_mult_a(multA72), .o_mult_b(multB72), .i_prod_in(prodIn),
    .o_acc_out(accOut72), .o_acc_valid(accValid72), .i_acc_ready(accReady),
    .o_overflow(overflow72), .o_busy(busy72)
  );

  wtm_product_accumulator #(.ACC_W(64)) dut64 (
    .i_clk(clk), .i_reset(resetN), .i_start(start), .i_len(len),
    .i_op_valid(opValid), .o_op_ready(opReady64), .i_op_a(opA), .i_op_b(opB),
    .o_mult_a(multA64), .o_mult_b(multB64), .i_prod_in(prodIn),
    .o_acc_out(accOut64), .o_acc_valid(accValid64), .i_acc_ready(accReady),
    .o_overflow(overflow64), .o_busy(busy64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the registered Wallace-tree multiplier (2-cycle latency).
  always @(posedge clk) begin
    mulStage1 <= {32'b0, multA72} * {32'b0, multB72};
    prodIn    <= mulStage1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b);
    opValid = v;
    opA     = a;
    opB     = b;
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    tick();
    nVectors++; if (accOut72 !== 72'h0) begin nMiscompares++; $display("[TB] FAIL reset_acc_out: got %h expected 0", accOut72); end
    nVectors++; if (accValid72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_acc_valid: got %b expected 0", accValid72); end
    nVectors++; if (overflow72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow72); end
    nVectors++; if (busy72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy72); end
    nVectors++; if (opReady72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_op_ready: got %b expected 0", opReady72); end
  endtask

  task automatic test_basic_job();
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    nVectors++; if (opReady72 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL basic_op_ready: got %b expected 1", opReady72); end
    nVectors++; if (busy72 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL basic_busy: got %b expected 1", busy72); end
    applyStimulus(1'b1, 32'd3, 32'd5);
    applyStimulus(1'b1, 32'd7, 32'd11);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd2);
    opValid = 1'b0;
    nVectors++; if (opReady72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_drain_op_ready: got %b expected 0", opReady72); end
    tick();
    nVectors++; if (accValid72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_valid_early: got %b expected 0", accValid72); end
    nVectors++; if (accOut72 !== 72'd92) begin nMiscompares++; $display("[TB] FAIL basic_partial_sum: got %h expected %h", accOut72, 72'd92); end
    tick();
    nVectors++; if (accValid72 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL basic_acc_valid: got %b expected 1", accValid72); end
    nVectors++; if (accOut72 !== 72'h2_0000_005A) begin nMiscompares++; $display("[TB] FAIL basic_acc_out: got %h expected %h", accOut72, 72'h2_0000_005A); end
    nVectors++; if (overflow72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_overflow: got %b expected 0", overflow72); end
    accReady = 1'b1;
    tick();
    accReady = 1'b0;
    nVectors++; if (accValid72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_valid_drop: got %b expected 0", accValid72); end
    nVectors++; if (busy72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy72); end
  endtask

  task automatic test_overflow();
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    opValid = 1'b0;
    tick();
    tick();
    nVectors++; if (accValid64 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovf64_acc_valid: got %b expected 1", accValid64); end
    nVectors++; if (accOut64 !== 64'hFFFF_FFFC_0000_0002) begin nMiscompares++; $display("[TB] FAIL ovf64_acc_out: got %h expected %h", accOut64, 64'hFFFF_FFFC_0000_0002); end
    nVectors++; if (overflow64 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL ovf64_overflow: got %b expected 1", overflow64); end
    nVectors++; if (accOut72 !== 72'h1_FFFF_FFFC_0000_0002) begin nMiscompares++; $display("[TB] FAIL ovf72_acc_out: got %h expected %h", accOut72, 72'h1_FFFF_FFFC_0000_0002); end
    nVectors++; if (overflow72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL ovf72_overflow: got %b expected 0", overflow72); end
    accReady = 1'b1;
    tick();
    accReady = 1'b0;
  endtask

  task automatic test_backpressure();
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'd100, 32'd200);
    // The gap carries junk operands whose products must never be summed.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'hDEAD, 32'hBEEF);
    applyStimulus(1'b1, 32'd9, 32'd9);
    opValid = 1'b0;
    tick();
    nVectors++; if (accValid72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL gap_valid_early: got %b expected 0", accValid72); end
    tick();
    nVectors++; if (accValid72 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL gap_acc_valid: got %b expected 1", accValid72); end
    nVectors++; if (accOut72 !== 72'd20081) begin nMiscompares++; $display("[TB] FAIL gap_acc_out: got %0d expected 20081", accOut72); end
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 8'd5;
      applyStimulus(1'b1, 32'd4, 32'd4);
      nVectors++; if (accOut72 !== 72'd20081) begin nMiscompares++; $display("[TB] FAIL hold_acc_out[%0d]: got %0d expected 20081", i, accOut72); end
      nVectors++; if (accValid72 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL hold_acc_valid[%0d]: got %b expected 1", i, accValid72); end
      nVectors++; if (opReady72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL hold_op_ready[%0d]: got %b expected 0", i, opReady72); end
    end
    // start stays high in the DONE-exit cycle; it must not launch a job.
    opValid = 1'b0;
    accReady = 1'b1;
    tick();
    start = 1'b0;
    accReady = 1'b0;
    nVectors++; if (busy72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL exit_busy: got %b expected 0", busy72); end
    nVectors++; if (accValid72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL exit_acc_valid: got %b expected 0", accValid72); end
    nVectors++; if (accOut72 !== 72'd20081) begin nMiscompares++; $display("[TB] FAIL exit_acc_out: got %0d expected 20081", accOut72); end
  endtask

  task automatic test_mid_reset();
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'd1000, 32'd1000);
    applyStimulus(1'b1, 32'd2000, 32'd2000);
    opValid = 1'b0;
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    nVectors++; if (accOut72 !== 72'h0) begin nMiscompares++; $display("[TB] FAIL midrst_acc_out: got %h expected 0", accOut72); end
    nVectors++; if (busy72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy72); end
    nVectors++; if (opReady72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL midrst_op_ready: got %b expected 0", opReady72); end
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 32'd6, 32'd7);
    opValid = 1'b0;
    tick();
    nVectors++; if (accValid72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL midrst_valid_early: got %b expected 0", accValid72); end
    tick();
    nVectors++; if (accValid72 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL midrst_acc_valid: got %b expected 1", accValid72); end
    nVectors++; if (accOut72 !== 72'd42) begin nMiscompares++; $display("[TB] FAIL midrst_acc_out: got %0d expected 42", accOut72); end
    nVectors++; if (overflow72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL midrst_overflow: got %b expected 0", overflow72); end
    accReady = 1'b1;
    tick();
    accReady = 1'b0;
  endtask

  task automatic test_zero_len();
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    nVectors++; if (opReady72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL zero_op_ready: got %b expected 0", opReady72); end
    applyStimulus(1'b1, 32'd5, 32'd5);
    opValid = 1'b0;
    nVectors++; if (accValid72 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL zero_acc_valid: got %b expected 1", accValid72); end
    nVectors++; if (accOut72 !== 72'h0) begin nMiscompares++; $display("[TB] FAIL zero_acc_out: got %h expected 0", accOut72); end
    nVectors++; if (overflow72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL zero_overflow: got %b expected 0", overflow72); end
    tick();
    tick();
    nVectors++; if (accOut72 !== 72'h0) begin nMiscompares++; $display("[TB] FAIL zero_no_accept: got %h expected 0", accOut72); end
    accReady = 1'b1;
    tick();
    accReady = 1'b0;
    nVectors++; if (busy72 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL zero_exit_busy: got %b expected 0", busy72); end
  endtask

  initial begin
    resetN   = 1'b0;
    start    = 1'b0;
    len      = 8'd0;
    opValid  = 1'b0;
    opA      = 32'd0;
    opB      = 32'd0;
    accReady = 1'b0;
    $display("[TB] starting wtm_product_accumulator bench");
    test_reset();
    test_basic_job();
    test_overflow();
    test_backpressure();
    test_mid_reset();
    test_zero_len();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
